// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the five-stage RV32I pipeline.
//   wb_sel_e   : write-back source select of an instruction
//   fwd_sel_e  : EX operand source select produced by the hazard unit
//   hz_state_e : hazard controller FSM states
package riscv_pipe_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EX operand.
//   src  in 5 : source register address of the EX operand
//   rd_m in 5 : MEM destination register, wr_m in 1: MEM writes it
//   rd_w in 5 : WB destination register,  wr_w in 1: WB writes it
//   sel  out 2: FWD_MEM / FWD_WB / FWD_RF (MEM is the younger result, so it wins)
module hazard_fwd_sel
   import riscv_pipe_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] rd_m,
   input  logic       wr_m,
   input  logic [4:0] rd_w,
   input  logic       wr_w,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (wr_m && (rd_m != 5'd0) && (rd_m == src)) begin
         sel = FWD_MEM;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32I core.
// Produces stalls, flushes and operand forward selects from ID/EX/MEM/WB
// state, and tracks multi-cycle data-memory waits with a timeout FSM.
//   Inputs : ID/EX/MEM/WB register addresses and write enables, EX wb select,
//            branch_taken_e, dmem_req_m / dmem_ack_m
//   Outputs: stall_{f,d,e,m}_o, flush_{d,e}_o, fwd_{a,b}_o, mem_timeout_o
// Stalls, flushes and forward selects are combinational; mem_timeout_o is
// registered and sticky until reset.
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [4:0] rs1_addr_d,
   input  logic [4:0] rs2_addr_d,
   input  logic       rs1_used_d,
   input  logic       rs2_used_d,
   input  logic [4:0] rs1_addr_e,
   input  logic [4:0] rs2_addr_e,
   input  logic [4:0] rd_addr_e,
   input  logic       reg_wr_en_e,
   input  logic [1:0] wb_sel_e,
   input  logic       branch_taken_e,
   input  logic [4:0] rd_addr_m,
   input  logic       reg_wr_en_m,
   input  logic [4:0] rd_addr_w,
   input  logic       reg_wr_en_w,
   input  logic       dmem_req_m,
   input  logic       dmem_ack_m,
   output logic       stall_f_o,
   output logic       stall_d_o,
   output logic       stall_e_o,
   output logic       stall_m_o,
   output logic       flush_d_o,
   output logic       flush_e_o,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o,
   output logic       mem_timeout_o
);

   // Imported after the port list so the wb_sel_e port name shadows the
   // package type of the same name.
   import riscv_pipe_pkg::*;

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   hz_state_e     state;
   logic [CW-1:0] cnt;
   logic          timeout_q;

   logic          mstall;
   logic          lu;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;

   assign mstall = dmem_req_m & ~dmem_ack_m;

   assign lu = reg_wr_en_e & (wb_sel_e == WB_MEM) & (rd_addr_e != 5'd0) &
               ((rs1_used_d & (rs1_addr_d == rd_addr_e)) |
                (rs2_used_d & (rs2_addr_d == rd_addr_e)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= RUN;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mstall) begin
                  state <= MEM_WAIT;
                  cnt   <= CW'(1);
               end
            end
            MEM_WAIT: begin
               // A completing ack beats the timeout check in the same cycle.
               if (dmem_ack_m || !dmem_req_m) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ERROR;
                  timeout_q <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ERROR: begin
               state <= ERROR;
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Held in reset, every output reads as idle regardless of inputs.
   always_comb begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      stall_e_o = 1'b0;
      stall_m_o = 1'b0;
      flush_d_o = 1'b0;
      flush_e_o = 1'b0;
      if (!rst_ni) begin
         stall_f_o = 1'b0;
      end else if (state == ERROR) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         stall_m_o = 1'b1;
         flush_e_o = 1'b1;
      end else if (mstall) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         stall_m_o = 1'b1;
      end else if (branch_taken_e) begin
         flush_d_o = 1'b1;
         flush_e_o = 1'b1;
      end else if (lu) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         flush_e_o = 1'b1;
      end
   end

   hazard_fwd_sel u_fwd_a (
      .src  (rs1_addr_e),
      .rd_m (rd_addr_m),
      .wr_m (reg_wr_en_m),
      .rd_w (rd_addr_w),
      .wr_w (reg_wr_en_w),
      .sel  (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .src  (rs2_addr_e),
      .rd_m (rd_addr_m),
      .wr_m (reg_wr_en_m),
      .rd_w (rd_addr_w),
      .wr_w (reg_wr_en_w),
      .sel  (fwd_b)
   );

   assign fwd_a_o       = rst_ni ? fwd_a : FWD_RF;
   assign fwd_b_o       = rst_ni ? fwd_b : FWD_RF;
   assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (TIMEOUT = 4).
// ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
module tb_hazard_ctrl;

   localparam logic [1:0] F_RF  = 2'd0;
   localparam logic [1:0] F_MEM = 2'd1;
   localparam logic [1:0] F_WB  = 2'd2;

   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_MSTL  = 6'b111100;
   localparam logic [5:0] C_BR    = 6'b000011;
   localparam logic [5:0] C_LU    = 6'b110001;
   localparam logic [5:0] C_ERR   = 6'b111101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e, rd_addr_e;
   logic       rs1_used_d, rs2_used_d, reg_wr_en_e, branch_taken_e;
   logic [1:0] wb_sel;
   logic [4:0] rd_addr_m, rd_addr_w;
   logic       reg_wr_en_m, reg_wr_en_w, dmem_req_m, dmem_ack_m;
   logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
   logic [1:0] fwd_a, fwd_b;
   logic [5:0] ctl;

   int errors = 0;
   int checks = 0;

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

   always #5 clk = ~clk;

   hazard_ctrl #(.TIMEOUT(4)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .rs1_addr_d     (rs1_addr_d),
      .rs2_addr_d     (rs2_addr_d),
      .rs1_used_d     (rs1_used_d),
      .rs2_used_d     (rs2_used_d),
      .rs1_addr_e     (rs1_addr_e),
      .rs2_addr_e     (rs2_addr_e),
      .rd_addr_e      (rd_addr_e),
      .reg_wr_en_e    (reg_wr_en_e),
      .wb_sel_e       (wb_sel),
      .branch_taken_e (branch_taken_e),
      .rd_addr_m      (rd_addr_m),
      .reg_wr_en_m    (reg_wr_en_m),
      .rd_addr_w      (rd_addr_w),
      .reg_wr_en_w    (reg_wr_en_w),
      .dmem_req_m     (dmem_req_m),
      .dmem_ack_m     (dmem_ack_m),
      .stall_f_o      (stall_f),
      .stall_d_o      (stall_d),
      .stall_e_o      (stall_e),
      .stall_m_o      (stall_m),
      .flush_d_o      (flush_d),
      .flush_e_o      (flush_e),
      .fwd_a_o        (fwd_a),
      .fwd_b_o        (fwd_b),
      .mem_timeout_o  (mem_timeout)
   );

   task automatic idle();
      rs1_addr_d = 0; rs2_addr_d = 0; rs1_used_d = 0; rs2_used_d = 0;
      rs1_addr_e = 0; rs2_addr_e = 0; rd_addr_e = 0; reg_wr_en_e = 0;
      wb_sel = 0; branch_taken_e = 0; rd_addr_m = 0; reg_wr_en_m = 0;
      rd_addr_w = 0; reg_wr_en_w = 0; dmem_req_m = 0; dmem_ack_m = 0;
   endtask

   // Advance to the start of the next cycle, just after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Load in EX writing x5 (lw x5), ID reads x5 via rs1 (add x6,x5,x1).
   task automatic set_load_use();
      reg_wr_en_e = 1; wb_sel = 2'd1; rd_addr_e = 5'd5;
      rs1_used_d = 1; rs1_addr_d = 5'd5; rs2_used_d = 1; rs2_addr_d = 5'd1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      // Drive active-looking inputs: everything must still read idle.
      dmem_req_m = 1; branch_taken_e = 1;
      rs1_addr_e = 5'd3; rd_addr_m = 5'd3; reg_wr_en_m = 1;
      #3;
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE);
      end
      checks++;
      if (fwd_a !== F_RF || fwd_b !== F_RF) begin
         errors++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b);
      end
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      idle();
      set_load_use();
      #1;
      checks++;
      if (ctl !== C_LU) begin
         errors++; $display("FAIL load_use got=%b exp=%b", ctl, C_LU);
      end
      // Load-use via rs2 only.
      rs1_used_d = 0; rs2_addr_d = 5'd5; #1;
      checks++;
      if (ctl !== C_LU) begin
         errors++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, C_LU);
      end
      // rs2 matches but is not read.
      rs2_used_d = 0; #1;
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL load_use_unused got=%b exp=%b", ctl, C_IDLE);
      end
      // Destination x0 never hazards.
      set_load_use(); rd_addr_e = 5'd0; rs1_addr_d = 5'd0; #1;
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, C_IDLE);
      end
      // ALU producer is forwarded, not stalled.
      set_load_use(); wb_sel = 2'd0; #1;
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL load_use_alu got=%b exp=%b", ctl, C_IDLE);
      end
      // Hazard lasts one cycle: next cycle the load has moved on.
      set_load_use(); next_cycle();
      idle(); #1;
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL load_use_clear got=%b exp=%b", ctl, C_IDLE);
      end
   endtask

   task automatic test_branch_over_lu();
      idle();
      set_load_use(); branch_taken_e = 1; #1;
      checks++;
      if (ctl !== C_BR) begin
         errors++; $display("FAIL branch_over_lu got=%b exp=%b", ctl, C_BR);
      end
      // Memory stall defers the branch.
      dmem_req_m = 1; #1;
      checks++;
      if (ctl !== C_MSTL) begin
         errors++; $display("FAIL mstall_over_branch got=%b exp=%b", ctl, C_MSTL);
      end
      // Req with same-cycle ack is not a stall.
      dmem_ack_m = 1; #1;
      checks++;
      if (ctl !== C_BR) begin
         errors++; $display("FAIL ack_no_stall got=%b exp=%b", ctl, C_BR);
      end
      idle(); next_cycle();
   endtask

   task automatic test_forwarding();
      idle();
      rs1_addr_e = 5'd7; rd_addr_m = 5'd7; rd_addr_w = 5'd7;
      reg_wr_en_m = 1; reg_wr_en_w = 1; rs2_addr_e = 5'd0; #1;
      checks++;
      if (fwd_a !== F_MEM) begin
         errors++; $display("FAIL fwd_mem_prio got=%0d exp=%0d", fwd_a, F_MEM);
      end
      checks++;
      if (fwd_b !== F_RF) begin
         errors++; $display("FAIL fwd_b_x0 got=%0d exp=%0d", fwd_b, F_RF);
      end
      reg_wr_en_m = 0; #1;
      checks++;
      if (fwd_a !== F_WB) begin
         errors++; $display("FAIL fwd_wb got=%0d exp=%0d", fwd_a, F_WB);
      end
      // x0 writes in MEM/WB are never forwarded.
      rs1_addr_e = 5'd0; rs2_addr_e = 5'd0; rd_addr_m = 5'd0; rd_addr_w = 5'd0;
      reg_wr_en_m = 1; #1;
      checks++;
      if (fwd_a !== F_RF || fwd_b !== F_RF) begin
         errors++; $display("FAIL fwd_x0 got=%0d/%0d exp=0/0", fwd_a, fwd_b);
      end
      // Independent A/B: A from WB, B from MEM.
      rs1_addr_e = 5'd9; rs2_addr_e = 5'd12; rd_addr_m = 5'd12; rd_addr_w = 5'd9; #1;
      checks++;
      if (fwd_a !== F_WB || fwd_b !== F_MEM) begin
         errors++; $display("FAIL fwd_split got=%0d/%0d exp=2/1", fwd_a, fwd_b);
      end
      idle();
   endtask

   task automatic test_mem_ack();
      idle();
      next_cycle();
      dmem_req_m = 1; #1;                       // cycle 0
      checks++;
      if (ctl !== C_MSTL) begin
         errors++; $display("FAIL ack_c0 got=%b exp=%b", ctl, C_MSTL);
      end
      next_cycle();                             // cycle 1
      checks++;
      if (ctl !== C_MSTL) begin
         errors++; $display("FAIL ack_c1 got=%b exp=%b", ctl, C_MSTL);
      end
      next_cycle(); dmem_ack_m = 1; #1;         // cycle 2
      checks++;
      if (ctl !== C_IDLE) begin
         errors++; $display("FAIL ack_c2 got=%b exp=%b", ctl, C_IDLE);
      end
      next_cycle(); idle(); branch_taken_e = 1; #1;   // cycle 3: back in RUN
      checks++;
      if (ctl !== C_BR || mem_timeout !== 1'b0) begin
         errors++; $display("FAIL ack_run got=%b/%b exp=%b/0", ctl, mem_timeout, C_BR);
      end
      idle();
      repeat (5) next_cycle();
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++; $display("FAIL ack_no_timeout got=%b exp=0", mem_timeout);
      end
   endtask

   task automatic test_timeout_reset();
      idle();
      next_cycle();
      dmem_req_m = 1;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) next_cycle();
         if (c == 6) branch_taken_e = 1;
         if (c == 7) begin branch_taken_e = 0; dmem_req_m = 0; end
         #1;
         checks++;
         if (c < 4) begin
            if (ctl !== C_MSTL || mem_timeout !== 1'b0) begin
               errors++;
               $display("FAIL timeout_wait c=%0d got=%b/%b exp=%b/0", c, ctl, mem_timeout, C_MSTL);
            end
         end else begin
            if (ctl !== C_ERR || mem_timeout !== 1'b1) begin
               errors++;
               $display("FAIL timeout_err c=%0d got=%b/%b exp=%b/1", c, ctl, mem_timeout, C_ERR);
            end
         end
      end
      next_cycle();                             // cycle 11
      rst_n = 0; #1;
      checks++;
      if (ctl !== C_IDLE || mem_timeout !== 1'b0 || fwd_a !== F_RF || fwd_b !== F_RF) begin
         errors++;
         $display("FAIL timeout_async_rst got=%b/%b exp=%b/0", ctl, mem_timeout, C_IDLE);
      end
      next_cycle();
      rst_n = 1; #1;
      branch_taken_e = 1; #1;
      checks++;
      if (ctl !== C_BR || mem_timeout !== 1'b0) begin
         errors++; $display("FAIL post_rst_run got=%b/%b exp=%b/0", ctl, mem_timeout, C_BR);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      idle();
      next_cycle();
      dmem_req_m = 1;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) next_cycle();
         dmem_ack_m = (c == 3);
         #1;
         checks++;
         if (c == 3) begin
            if (ctl !== C_IDLE || mem_timeout !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ack c=%0d got=%b/%b exp=%b/0", c, ctl, mem_timeout, C_IDLE);
            end
         end else if (c < 8) begin
            if (ctl !== C_MSTL || mem_timeout !== 1'b0) begin
               errors++;
               $display("FAIL b2b_wait c=%0d got=%b/%b exp=%b/0", c, ctl, mem_timeout, C_MSTL);
            end
         end else begin
            if (ctl !== C_ERR || mem_timeout !== 1'b1) begin
               errors++;
               $display("FAIL b2b_timeout c=%0d got=%b/%b exp=%b/1", c, ctl, mem_timeout, C_ERR);
            end
         end
      end
      do_reset();
   endtask

   initial begin
      idle();
      rst_n = 0;
      #2;
      test_reset();
      test_load_use();
      test_branch_over_lu();
      test_forwarding();
      test_mem_ack();
      test_timeout_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
